// File: rtl/seg_scan_decoder_pkg.sv
// Shared segment encodings, filter states and the seg->hex decode for the scan decoder.
// Latency: none (constants, types and a pure function).
// Backpressure: none.
package seg_pkg;

    // Active-low {sa,sb,sc,sd,se,sf,sg}
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] nibble;
    } dec_t;

    // Blank counts as legal with nibble 0; anything off-table is illegal.
    function automatic dec_t seg_decode(input logic [6:0] s);
        dec_t d;
        d = '{legal: 1'b1, blank: 1'b0, nibble: 4'h0};
        case (s)
            SEG_0:     d.nibble = 4'h0;
            SEG_1:     d.nibble = 4'h1;
            SEG_2:     d.nibble = 4'h2;
            SEG_3:     d.nibble = 4'h3;
            SEG_4:     d.nibble = 4'h4;
            SEG_5:     d.nibble = 4'h5;
            SEG_6:     d.nibble = 4'h6;
            SEG_7:     d.nibble = 4'h7;
            SEG_8:     d.nibble = 4'h8;
            SEG_9:     d.nibble = 4'h9;
            SEG_A:     d.nibble = 4'hA;
            SEG_B:     d.nibble = 4'hB;
            SEG_C:     d.nibble = 4'hC;
            SEG_D:     d.nibble = 4'hD;
            SEG_E:     d.nibble = 4'hE;
            SEG_F:     d.nibble = 4'hF;
            SEG_BLANK: d.blank  = 1'b1;
            default:   d.legal  = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Bundle of the observed 7-segment bus and the reconstructed digit results.
// Latency: none (wires only).
// Backpressure: none; the display bus is free-running and results are level/pulse outputs.
interface seg_scan_decoder_if #(
    parameter int NUM_DIGITS = 4
);
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    sample_en;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic [NUM_DIGITS-1:0]   digit_blank;
    logic                    frame_done;
    logic                    pat_err;
    logic                    multi_an_err;
    logic                    stale;

    modport master (
        output an, seg, sample_en,
        input  digits, digit_valid, digit_blank, frame_done, pat_err, multi_an_err, stale
    );

    modport slave (
        input  an, seg, sample_en,
        output digits, digit_valid, digit_blank, frame_done, pat_err, multi_an_err, stale
    );
endinterface

// File: rtl/seg7_to_hex.sv
// Combinational decode of one active-low 7-segment pattern into {legal, blank, nibble}.
// Latency: 0 cycles.
// Backpressure: none.
module seg7_to_hex
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic       blank,
    output logic [3:0] nibble
);
    dec_t d;

    assign d      = seg_decode(seg);
    assign legal  = d.legal;
    assign blank  = d.blank;
    assign nibble = d.nibble;
endmodule

// File: rtl/seg_scan_decoder.sv
// Reconstructs the hex digits shown on a multiplexed active-low 7-segment bus.
// Latency: 2 sync clk + STABLE_CYCLES enabled samples + 1 clk from a stable bus to outputs.
// Backpressure: none; the filter advances only on sample_en and otherwise holds.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst_n,
    seg_scan_decoder_if.slave bus
);
    localparam int          IDXW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0]  STABLE_N = 8'(STABLE_CYCLES);
    localparam logic [15:0] WD_LAST  = 16'(TIMEOUT_CYCLES - 1);

    // Sync flops reset to the idle bus so no phantom anodes appear after reset.
    logic [NUM_DIGITS-1:0] an_s1, an_s2;
    logic [6:0]            seg_s1, seg_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_s1  <= '1;
            an_s2  <= '1;
            seg_s1 <= '1;
            seg_s2 <= '1;
        end else begin
            an_s1  <= bus.an;
            an_s2  <= an_s1;
            seg_s1 <= bus.seg;
            seg_s2 <= seg_s1;
        end
    end

    logic [NUM_DIGITS-1:0] act;
    logic                  any_act, multi_act;
    logic [IDXW-1:0]       act_idx;

    assign act       = ~an_s2;
    assign any_act   = |act;
    assign multi_act = |(act & (act - NUM_DIGITS'(1)));

    always_comb begin
        act_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (act[i]) act_idx = IDXW'(i);
        end
    end

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [6:0]      pat_q, pat_d;
    logic            commit_d, multi_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        pat_d    = pat_q;
        commit_d = 1'b0;
        multi_d  = 1'b0;
        if (bus.sample_en) begin
            if (!any_act) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (multi_act) begin
                multi_d = 1'b1;
                state_d = IDLE;
                cnt_d   = '0;
            end else if (state_q == IDLE || act_idx != idx_q || seg_s2 != pat_q) begin
                idx_d = act_idx;
                pat_d = seg_s2;
                cnt_d = 8'd1;
                if (STABLE_N == 8'd1) begin
                    commit_d = 1'b1;
                    state_d  = HOLD;
                end else begin
                    state_d  = TRACK;
                end
            end else if (state_q == TRACK) begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_d == STABLE_N) begin
                    commit_d = 1'b1;
                    state_d  = HOLD;
                end
            end
            // HOLD on an unchanged digit: already committed, nothing to do.
        end
    end

    logic            commit_q, multi_q;
    logic [IDXW-1:0] cidx_q;
    logic [6:0]      cpat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            pat_q    <= '0;
            commit_q <= 1'b0;
            multi_q  <= 1'b0;
            cidx_q   <= '0;
            cpat_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            pat_q    <= pat_d;
            commit_q <= commit_d;
            multi_q  <= multi_d;
            cidx_q   <= idx_d;
            cpat_q   <= pat_d;
        end
    end

    logic       c_legal, c_blank;
    logic [3:0] c_nib;

    seg7_to_hex u_dec (
        .seg    (cpat_q),
        .legal  (c_legal),
        .blank  (c_blank),
        .nibble (c_nib)
    );

    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0]   valid_q, blank_q, seen_q, seen_nxt, commit_bit;
    logic                    frame_q, perr_q, stale_q;
    logic [15:0]             wd_q;

    assign commit_bit = NUM_DIGITS'(1) << cidx_q;
    assign seen_nxt   = seen_q | commit_bit;

    // A commit always wins over watchdog expiry in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q <= '0;
            valid_q  <= '0;
            blank_q  <= '0;
            seen_q   <= '0;
            frame_q  <= 1'b0;
            perr_q   <= 1'b0;
            stale_q  <= 1'b0;
            wd_q     <= '0;
        end else begin
            frame_q <= 1'b0;
            perr_q  <= 1'b0;
            if (commit_q) begin
                wd_q    <= '0;
                stale_q <= 1'b0;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (cidx_q == IDXW'(i)) begin
                        if (c_legal) begin
                            digits_q[4*i +: 4] <= c_blank ? 4'h0 : c_nib;
                            valid_q[i]         <= 1'b1;
                            blank_q[i]         <= c_blank;
                        end else begin
                            valid_q[i] <= 1'b0;
                            blank_q[i] <= 1'b0;
                        end
                    end
                end
                perr_q <= ~c_legal;
                if (&seen_nxt) begin
                    seen_q  <= '0;
                    frame_q <= 1'b1;
                end else begin
                    seen_q  <= seen_nxt;
                end
            end else begin
                if (wd_q != 16'hFFFF) wd_q <= wd_q + 16'd1;
                if (wd_q == WD_LAST) begin
                    stale_q <= 1'b1;
                    valid_q <= '0;
                end
            end
        end
    end

    assign bus.digits       = digits_q;
    assign bus.digit_valid  = valid_q;
    assign bus.digit_blank  = blank_q;
    assign bus.frame_done   = frame_q;
    assign bus.pat_err      = perr_q;
    assign bus.multi_an_err = multi_q;
    assign bus.stale        = stale_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboarded bench: per-cycle expected outputs come from a run-length model of the bus.
module tb_seg_scan_decoder;
    import seg_pkg::*;

    localparam int ND   = 4;
    localparam int STAB = 4;
    localparam int TMO  = 100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

    seg_scan_decoder #(
        .NUM_DIGITS     (ND),
        .STABLE_CYCLES  (STAB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [6:0] xpat;
    logic       xlegal, xblank;
    logic [3:0] xnib;

    seg7_to_hex u_xdec (
        .seg    (xpat),
        .legal  (xlegal),
        .blank  (xblank),
        .nibble (xnib)
    );

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  valid;
        logic [3:0]  blank;
        logic        fd;
        logic        pe;
        logic        me;
        logic        st;
    } snap_t;

    snap_t exp_q[$];
    int    tests = 0;
    int    fails = 0;

    logic [6:0] ref_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic void ref_decode(input logic [6:0] p, output bit lg, output bit bk,
                                       output logic [3:0] nb);
        lg = 0;
        bk = 0;
        nb = 4'h0;
        if (p == 7'h7F) begin
            lg = 1;
            bk = 1;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (ref_tab[i] == p) begin
                    lg = 1;
                    nb = 4'(i);
                end
            end
        end
    endfunction

    // Reference model: bus history delayed by the synchroniser, a run of identical
    // one-hot samples, and a commit scheduled one cycle after the run hits STAB.
    logic [3:0] h_an[$];
    logic [6:0] h_seg[$];
    int         run_len, run_idx, pend_idx, since;
    logic [6:0] run_seg, pend_seg;
    bit         pend;
    logic [3:0] seen;
    snap_t      cur;

    task automatic model_reset();
        h_an  = '{4'hF, 4'hF};
        h_seg = '{7'h7F, 7'h7F};
        run_len = 0;
        run_idx = 0;
        run_seg = '0;
        pend = 0;
        pend_idx = 0;
        pend_seg = '0;
        seen = '0;
        since = 0;
        cur = '0;
    endtask

    task automatic model_step(input logic [3:0] a, input logic [6:0] s, input logic e);
        snap_t      nx;
        bit         lg, bk;
        logic [3:0] nb, da;
        logic [6:0] ds;
        int         ones, idx;
        nx = cur;
        nx.fd = 0;
        nx.pe = 0;
        nx.me = 0;
        if (pend) begin
            since = 0;
            nx.st = 0;
            ref_decode(pend_seg, lg, bk, nb);
            if (lg) begin
                nx.digits[pend_idx*4 +: 4] = bk ? 4'h0 : nb;
                nx.valid[pend_idx] = 1'b1;
                nx.blank[pend_idx] = bk;
            end else begin
                nx.valid[pend_idx] = 1'b0;
                nx.blank[pend_idx] = 1'b0;
                nx.pe = 1'b1;
            end
            seen[pend_idx] = 1'b1;
            if (seen == 4'hF) begin
                nx.fd = 1'b1;
                seen = '0;
            end
        end else begin
            since++;
            if (since == TMO) nx.valid = '0;
            nx.st = (since >= TMO);
        end
        pend = 0;
        da = h_an.pop_front();
        ds = h_seg.pop_front();
        h_an.push_back(a);
        h_seg.push_back(s);
        if (e) begin
            ones = 0;
            idx = 0;
            for (int i = 0; i < ND; i++) begin
                if (!da[i]) begin
                    ones++;
                    idx = i;
                end
            end
            if (ones == 0) begin
                run_len = 0;
            end else if (ones > 1) begin
                nx.me = 1'b1;
                run_len = 0;
            end else begin
                if (run_len > 0 && idx == run_idx && ds == run_seg) begin
                    run_len++;
                end else begin
                    run_idx = idx;
                    run_seg = ds;
                    run_len = 1;
                end
                if (run_len == STAB) begin
                    pend = 1;
                    pend_idx = idx;
                    pend_seg = ds;
                end
                if (run_len > STAB) run_len = STAB + 1;
            end
        end
        cur = nx;
        exp_q.push_back(nx);
    endtask

    // Drives one cycle; the queue always ends with the snapshot for the current cycle
    // and each call appends the snapshot expected after the next clock edge.
    task automatic step(input logic [3:0] a, input logic [6:0] s, input logic e, input bit rst);
        @(posedge clk);
        #1;
        bus.an = a;
        bus.seg = s;
        bus.sample_en = e;
        if (rst) begin
            if (rst_n || exp_q.size() == 0) begin
                exp_q.delete();
                exp_q.push_back('0);
            end
            rst_n = 1'b0;
            model_reset();
            exp_q.push_back('0);
        end else begin
            rst_n = 1'b1;
            model_step(a, s, e);
        end
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        for (int i = 0; i < n; i++) step(a, s, 1'b1, 1'b0);
    endtask

    initial begin : monitor
        snap_t e, g;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {bus.digits, bus.digit_valid, bus.digit_blank,
                     bus.frame_done, bus.pat_err, bus.multi_an_err, bus.stale};
                tests++;
                if (g !== e) begin
                    fails++;
                    $display("FAIL cycle_out t=%0t got dig=%h vld=%b blk=%b fd/pe/me/st=%b%b%b%b required dig=%h vld=%b blk=%b fd/pe/me/st=%b%b%b%b",
                             $time, g.digits, g.valid, g.blank, g.fd, g.pe, g.me, g.st,
                             e.digits, e.valid, e.blank, e.fd, e.pe, e.me, e.st);
                end
            end
        end
    end

    initial begin : stim
        bit         lg, bk;
        logic [3:0] nb, ra;
        logic [6:0] rs;
        int         kind, n;

        bus.an = '1;
        bus.seg = '1;
        bus.sample_en = 1'b0;
        xpat = '0;
        model_reset();

        for (int p = 0; p < 128; p++) begin
            xpat = 7'(p);
            #1;
            ref_decode(xpat, lg, bk, nb);
            tests++;
            if ({xlegal, xblank, xnib} !== {lg, bk, nb}) begin
                fails++;
                $display("FAIL decode pat=%b got %b%b%h required %b%b%h",
                         xpat, xlegal, xblank, xnib, lg, bk, nb);
            end
        end

        repeat (3) step(4'hF, 7'h7F, 1'b0, 1'b1);

        hold(4'b1110, 7'b0010010, 10);

        hold(4'b1110, 7'b0110001, 6);
        hold(4'b1101, 7'b1000010, 6);
        hold(4'b1011, 7'b0110000, 6);
        hold(4'b0111, 7'b0111000, 6);

        hold(4'b1101, 7'b1111111, 6);
        hold(4'b1101, 7'b1010101, 6);

        hold(4'b1100, 7'b0000001, 1);
        hold(4'b1111, 7'b0000001, 4);

        for (int i = 0; i < 8; i++) hold(4'b1011, (i % 2) ? SEG_3 : SEG_8, 2);

        hold(4'b1011, 7'b0001111, 6);
        hold(4'b1111, 7'b1111111, 110);
        hold(4'b1011, 7'b0000100, 7);

        hold(4'b1110, 7'b0100100, 5);
        repeat (2) step(4'b1110, 7'b0100100, 1'b1, 1'b1);
        hold(4'b1110, 7'b0100100, 9);

        for (int t = 0; t < 300; t++) begin
            kind = $urandom_range(0, 9);
            if (kind < 7) ra = ~(4'd1 << $urandom_range(0, 3));
            else if (kind < 9) ra = 4'hF;
            else ra = 4'($urandom);
            kind = $urandom_range(0, 9);
            if (kind == 0) rs = 7'($urandom);
            else if (kind == 1) rs = 7'h7F;
            else rs = ref_tab[$urandom_range(0, 15)];
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) step(ra, rs, 1'($urandom_range(0, 3) != 0), 1'b0);
            if (t == 150) repeat (2) step(ra, rs, 1'b0, 1'b1);
        end

        hold(4'hF, 7'h7F, 3);
        @(negedge clk);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
